// File: rtl/data_router_pkg.sv
// Shared types and widths for the data router and its fetch sequencer.
package data_router_pkg;

    typedef enum logic [1:0] {RR = 2'b00, BR = 2'b01, RP = 2'b10, NE = 2'b11} rpsel_e;

    typedef enum logic [2:0] {IDLE, FILL, SERVE, ADV, DONE} fetch_state_e;

    localparam int BANK_W = 8;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 28;

endpackage

// File: rtl/data_router_fetch_ctrl_if.sv
// Router read port plus window handshake; master = fetch controller, slave = router/PE side.
interface data_router_fetch_ctrl_if #(
    parameter int DW    = 32,
    parameter int POY   = 3,
    parameter int BUFW  = 32,
    parameter int KSIZE = 3
) ();
    import data_router_pkg::*;

    logic [BANK_W-1:0]                         bank;
    logic [ROW_W-1:0]                          row;
    logic [COL_W-1:0]                          col;
    rpsel_e                                    rpsel;
    logic [POY-1:0][BUFW-1:0][DW-1:0]          rdata;
    logic [POY-1:0][KSIZE-1:0][BUFW-1:0][DW-1:0] win_data;
    logic                                      win_valid;
    logic                                      win_ready;
    logic [ROW_W-1:0]                          win_top;

    modport master (
        output bank, row, col, rpsel, win_data, win_valid, win_top,
        input  rdata, win_ready
    );

    modport slave (
        input  bank, row, col, rpsel, win_data, win_valid, win_top,
        output rdata, win_ready
    );

endinterface

// File: rtl/row_window_shreg.sv
// Per-bank KSIZE-row shift register; row 0 is the oldest, new rows enter at KSIZE-1.
module row_window_shreg #(
    parameter int DW    = 32,
    parameter int POY   = 3,
    parameter int BUFW  = 32,
    parameter int KSIZE = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      shift_en,
    input  logic [POY-1:0][BUFW-1:0][DW-1:0]          din,
    output logic [POY-1:0][KSIZE-1:0][BUFW-1:0][DW-1:0] dout
);

    for (genvar p = 0; p < POY; p++) begin : g_bank
        logic [KSIZE-1:0][BUFW-1:0][DW-1:0] rows_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rows_q <= '0;
            end else if (shift_en) begin
                for (int k = 0; k < KSIZE - 1; k++) rows_q[k] <= rows_q[k+1];
                rows_q[KSIZE-1] <= din[p];
            end
        end

        assign dout[p] = rows_q;
    end

endmodule

// File: rtl/data_router_fetch_ctrl.sv
// Fetch sequencer: walks buffer rows per block and serves sliding KSIZE-row windows.
// Optional DATA_ROUTER_FETCH_PERF_EN adds saturating stall_cnt / fetch_cnt outputs.
module data_router_fetch_ctrl
    import data_router_pkg::*;
#(
    parameter int DW     = 32,
    parameter int POY    = 3,
    parameter int POX    = 16,
    parameter int BUFW   = 32,
    parameter int BUFH   = 3,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic blkend,
    data_router_fetch_ctrl_if.master bus,
    output logic blk_done,
    output logic busy,
    output logic err_ovf
`ifdef DATA_ROUTER_FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] fetch_cnt
`endif
);

    if (BUFH > 256 || KSIZE < 1 || KSIZE > BUFH || STRIDE < 1 || STRIDE > KSIZE || POX < 1)
    begin : g_bad_cfg
        $error("data_router_fetch_ctrl: illegal BUFH/KSIZE/STRIDE/POX combination");
    end

    localparam logic [7:0] K8 = 8'(KSIZE);
    localparam logic [7:0] S8 = 8'(STRIDE);

    fetch_state_e     state_q, state_d;
    logic [ROW_W-1:0] top_q, top_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       cnt_iss_q, cnt_iss_d;
    logic [7:0]       cnt_cap_q, cnt_cap_d;
    // [0]: a row address is on the bus this cycle; [1]: its data is on rdata this cycle
    logic [1:0]       vld_pipe_q, vld_pipe_d;
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_top_q, win_top_d;
    logic             blk_done_q, blk_done_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             busy_q;

    logic [7:0]       nrows;
    logic [ROW_W-1:0] base_row;
    logic [9:0]       win_end;

    // FILL loads a full window; ADV only tops it up with the STRIDE newest rows.
    assign nrows    = (state_q == FILL) ? K8 : S8;
    assign base_row = (state_q == FILL) ? top_q : top_q + K8 - S8;
    assign win_end  = 10'(top_q) + 10'(STRIDE) + 10'(KSIZE);

    always_comb begin
        state_d     = state_q;
        top_d       = top_q;
        row_d       = row_q;
        cnt_iss_d   = cnt_iss_q;
        cnt_cap_d   = cnt_cap_q;
        vld_pipe_d  = {vld_pipe_q[0], 1'b0};
        win_valid_d = win_valid_q;
        win_top_d   = win_top_q;
        blk_done_d  = 1'b0;
        pend_d      = pend_q;
        err_d       = err_q;

        if (vld_pipe_q[1]) cnt_cap_d = cnt_cap_q + 8'd1;

        if (blkend && state_q != IDLE) begin
            if (pend_q) err_d  = 1'b1;
            else        pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (blkend || pend_q) begin
                    state_d   = FILL;
                    pend_d    = 1'b0;
                    top_d     = '0;
                    cnt_iss_d = '0;
                    cnt_cap_d = '0;
                end
            end
            FILL, ADV: begin
                if (cnt_iss_q < nrows) begin
                    row_d         = base_row + cnt_iss_q;
                    vld_pipe_d[0] = 1'b1;
                    cnt_iss_d     = cnt_iss_q + 8'd1;
                end
                if (vld_pipe_q[1] && cnt_cap_q == nrows - 8'd1) begin
                    state_d     = SERVE;
                    win_valid_d = 1'b1;
                    win_top_d   = top_q;
                end
            end
            SERVE: begin
                if (win_valid_q && bus.win_ready) begin
                    win_valid_d = 1'b0;
                    cnt_iss_d   = '0;
                    cnt_cap_d   = '0;
                    if (win_end > 10'(BUFH)) begin
                        state_d    = DONE;
                        blk_done_d = 1'b1;
                    end else begin
                        top_d   = top_q + S8;
                        state_d = ADV;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            top_q       <= '0;
            row_q       <= '0;
            cnt_iss_q   <= '0;
            cnt_cap_q   <= '0;
            vld_pipe_q  <= '0;
            win_valid_q <= 1'b0;
            win_top_q   <= '0;
            blk_done_q  <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            row_q       <= row_d;
            cnt_iss_q   <= cnt_iss_d;
            cnt_cap_q   <= cnt_cap_d;
            vld_pipe_q  <= vld_pipe_d;
            win_valid_q <= win_valid_d;
            win_top_q   <= win_top_d;
            blk_done_q  <= blk_done_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    row_window_shreg #(
        .DW(DW), .POY(POY), .BUFW(BUFW), .KSIZE(KSIZE)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .shift_en (vld_pipe_q[1]),
        .din      (bus.rdata),
        .dout     (bus.win_data)
    );

    assign bus.bank      = '0;
    assign bus.col       = '0;
    assign bus.rpsel     = RR;
    assign bus.row       = row_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_top   = win_top_q;
    assign blk_done      = blk_done_q;
    assign busy          = busy_q;
    assign err_ovf       = err_q;

`ifdef DATA_ROUTER_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, fetch_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            if (win_valid_q && !bus.win_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (vld_pipe_q[0] && fetch_cnt_q != '1)                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_data_router_fetch_ctrl.sv
// Scoreboard bench: stimulus pushes expected windows/blocks, negedge monitors pop and compare.
module tb_data_router_fetch_ctrl;
    import data_router_pkg::*;

    localparam int DW = 32, POY = 3, BUFW = 32, KSIZE = 3;
    typedef logic [POY-1:0][KSIZE-1:0][BUFW-1:0][DW-1:0] win_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    data_router_fetch_ctrl_if #(.DW(DW), .POY(POY), .BUFW(BUFW), .KSIZE(KSIZE)) bus_b ();
    data_router_fetch_ctrl_if #(.DW(DW), .POY(POY), .BUFW(BUFW), .KSIZE(KSIZE)) bus_c ();
    logic blkend_b, done_b, busy_b, err_b;
    logic blkend_c, done_c, busy_c, err_c;
`ifdef DATA_ROUTER_FETCH_PERF_EN
    logic [31:0] stall_b, fetch_b, stall_c, fetch_c;
`endif

    data_router_fetch_ctrl #(.DW(DW), .POY(POY), .POX(16), .BUFW(BUFW), .BUFH(5), .KSIZE(KSIZE), .STRIDE(1)) u_b (
        .clk(clk), .rst(rst), .blkend(blkend_b), .bus(bus_b.master),
        .blk_done(done_b), .busy(busy_b), .err_ovf(err_b)
`ifdef DATA_ROUTER_FETCH_PERF_EN
        , .stall_cnt(stall_b), .fetch_cnt(fetch_b)
`endif
    );

    data_router_fetch_ctrl #(.DW(DW), .POY(POY), .POX(16), .BUFW(BUFW), .BUFH(6), .KSIZE(KSIZE), .STRIDE(2)) u_c (
        .clk(clk), .rst(rst), .blkend(blkend_c), .bus(bus_c.master),
        .blk_done(done_c), .busy(busy_c), .err_ovf(err_c)
`ifdef DATA_ROUTER_FETCH_PERF_EN
        , .stall_cnt(stall_c), .fetch_cnt(fetch_c)
`endif
    );

    // Router model: one-cycle read latency, word = 100*bank + row + column
    always @(posedge clk) begin
        for (int p = 0; p < POY; p++)
            for (int c = 0; c < BUFW; c++) begin
                bus_b.rdata[p][c] <= 32'(100 * p + int'(bus_b.row) + c);
                bus_c.rdata[p][c] <= 32'(100 * p + int'(bus_c.row) + c);
            end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic win_t exp_win(input int top);
        win_t w;
        for (int p = 0; p < POY; p++)
            for (int k = 0; k < KSIZE; k++)
                for (int c = 0; c < BUFW; c++)
                    w[p][k][c] = 32'(100 * p + top + k + c);
        return w;
    endfunction

    int exp_top_b[$], exp_nblk_b[$], exp_top_c[$], exp_nblk_c[$];
    int nwin_b = 0, age_b = 99, dcnt_b = 0, maxrow_b = 0;
    int nwin_c = 0, age_c = 99, dcnt_c = 0, maxrow_c = 0;

    always @(negedge clk) begin
        if (rst) begin
            nwin_b = 0;
            age_b  = 99;
        end else begin
            int t, n;
            age_b++;
            if (bus_b.win_valid && bus_b.win_ready) begin
                if (exp_top_b.size() == 0) check("B unexpected window", 1, 0);
                else begin
                    t = exp_top_b.pop_front();
                    check("B win_top", int'(bus_b.win_top), t);
                    check("B win_data", int'(bus_b.win_data == exp_win(t)), 1);
                    if (t == 0) check("B win_data[2][1][5]", int'(bus_b.win_data[2][1][5]), 206);
                end
                nwin_b++;
                age_b = 0;
            end
            if (done_b) begin
                dcnt_b++;
                if (exp_nblk_b.size() == 0) check("B unexpected blk_done", 1, 0);
                else begin
                    n = exp_nblk_b.pop_front();
                    check("B windows per block", nwin_b, n);
                    check("B blk_done latency", age_b, 1);
                end
                nwin_b = 0;
            end
            if (int'(bus_b.row) > maxrow_b) maxrow_b = int'(bus_b.row);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            nwin_c = 0;
            age_c  = 99;
        end else begin
            int t, n;
            age_c++;
            if (bus_c.win_valid && bus_c.win_ready) begin
                if (exp_top_c.size() == 0) check("C unexpected window", 1, 0);
                else begin
                    t = exp_top_c.pop_front();
                    check("C win_top", int'(bus_c.win_top), t);
                    check("C win_data", int'(bus_c.win_data == exp_win(t)), 1);
                end
                nwin_c++;
                age_c = 0;
            end
            if (done_c) begin
                dcnt_c++;
                if (exp_nblk_c.size() == 0) check("C unexpected blk_done", 1, 0);
                else begin
                    n = exp_nblk_c.pop_front();
                    check("C windows per block", nwin_c, n);
                    check("C blk_done latency", age_c, 1);
                end
                nwin_c = 0;
            end
            if (int'(bus_c.row) > maxrow_c) maxrow_c = int'(bus_c.row);
        end
    end

    task automatic pulse_b();
        @(posedge clk); #1 blkend_b = 1'b1;
        @(posedge clk); #1 blkend_b = 1'b0;
    endtask

    task automatic wait_done(input bit is_c, input int target, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = is_c ? (dcnt_c >= target) : (dcnt_b >= target);
        end
        if (!hit) check(is_c ? "C blk_done timeout" : "B blk_done timeout", 0, 1);
    endtask

    task automatic wait_valid_b(input bit need_ready, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = bus_b.win_valid && (!need_ready || bus_b.win_ready);
        end
        if (!hit) check("B win_valid timeout", 0, 1);
    endtask

    initial begin
        win_t       snap;
        logic [7:0] snap_top, snap_row;
        int         d0;

        rst = 1'b1;
        blkend_b = 1'b0; blkend_c = 1'b0;
        bus_b.win_ready = 1'b1; bus_c.win_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst win_valid", int'(bus_b.win_valid), 0);
        check("rst busy",      int'(busy_b), 0);
        check("rst err_ovf",   int'(err_b), 0);
        check("rst blk_done",  int'(done_b), 0);
        check("rst row",       int'(bus_b.row), 0);
        check("rst win_top",   int'(bus_b.win_top), 0);
        check("rst win_data",  int'(bus_b.win_data == '0), 1);
        check("rst rpsel",     int'(bus_b.rpsel), int'(RR));
        check("rst bank/col",  int'(bus_b.bank) + int'(bus_b.col), 0);
        @(posedge clk); #1 rst = 1'b0;

        // BUFH=5 KSIZE=3 STRIDE=1: three windows, rows 0..4 fetched
        exp_top_b.push_back(0); exp_top_b.push_back(1); exp_top_b.push_back(2);
        exp_nblk_b.push_back(3);
        pulse_b();
        check("B busy after start", int'(busy_b), 1);
        wait_done(1'b0, 1, 80);
        @(negedge clk);
        check("B row back to 0", int'(bus_b.row), 0);
        check("B idle busy", int'(busy_b), 0);
        check("B max row", maxrow_b, 4);
`ifdef DATA_ROUTER_FETCH_PERF_EN
        check("B fetch_cnt", int'(fetch_b), 5);
`endif

        // BUFH=6 STRIDE=2: windows at 0 and 2, row 5 never requested
        exp_top_c.push_back(0); exp_top_c.push_back(2);
        exp_nblk_c.push_back(2);
        @(posedge clk); #1 blkend_c = 1'b1;
        @(posedge clk); #1 blkend_c = 1'b0;
        wait_done(1'b1, 1, 80);
        check("C max row", maxrow_c, 4);

        // Back-pressure: window, top and row must hold for 20 stalled cycles
        bus_b.win_ready = 1'b0;
        exp_top_b.push_back(0); exp_top_b.push_back(1); exp_top_b.push_back(2);
        exp_nblk_b.push_back(3);
        pulse_b();
        wait_valid_b(1'b0, 30);
        snap = bus_b.win_data; snap_top = bus_b.win_top; snap_row = bus_b.row;
        repeat (19) begin
            @(negedge clk);
            check("stall hold", int'(bus_b.win_valid && bus_b.win_data == snap &&
                  bus_b.win_top == snap_top && bus_b.row == snap_row), 1);
        end
        @(posedge clk); #1 bus_b.win_ready = 1'b1;
`ifdef DATA_ROUTER_FETCH_PERF_EN
        @(negedge clk);
        check("stall_cnt", int'(stall_b), 20);
`endif
        wait_done(1'b0, 2, 80);

        // blkend in FILL -> pending restart; another in SERVE -> overflow
        bus_b.win_ready = 1'b0;
        for (int blk = 0; blk < 2; blk++) begin
            exp_top_b.push_back(0); exp_top_b.push_back(1); exp_top_b.push_back(2);
            exp_nblk_b.push_back(3);
        end
        pulse_b();
        pulse_b();
        wait_valid_b(1'b0, 30);
        check("err_ovf before overflow", int'(err_b), 0);
        pulse_b();
        @(negedge clk);
        check("err_ovf set", int'(err_b), 1);
        bus_b.win_ready = 1'b1;
        wait_done(1'b0, 4, 150);
        check("err_ovf sticky", int'(err_b), 1);

        // Async reset during ADV abandons the block without blk_done
        exp_top_b.push_back(0);
        pulse_b();
        wait_valid_b(1'b1, 30);
        @(negedge clk);
        check("in ADV busy", int'(busy_b), 1);
        d0 = dcnt_b;
        #1 rst = 1'b1;
        #1;
        check("mid-ADV rst win_valid", int'(bus_b.win_valid), 0);
        check("mid-ADV rst busy",      int'(busy_b), 0);
        check("mid-ADV rst row",       int'(bus_b.row), 0);
        check("mid-ADV rst win_data",  int'(bus_b.win_data == '0), 1);
        check("mid-ADV rst err_ovf",   int'(err_b), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no blk_done after rst", dcnt_b, d0);
        exp_top_b.push_back(0); exp_top_b.push_back(1); exp_top_b.push_back(2);
        exp_nblk_b.push_back(3);
        pulse_b();
        wait_done(1'b0, d0 + 1, 80);

        repeat (3) @(negedge clk);
        check("B windows left", exp_top_b.size() + exp_nblk_b.size(), 0);
        check("C windows left", exp_top_c.size() + exp_nblk_c.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
